// File: rtl/adder_result_accum.sv
// Block accumulator behind adder_8bit: sums {overflow, sum} samples into a
// saturating total and hands the closed block downstream over valid/ready.
module adder_result_accum #(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 12,
  parameter int MAX_COUNT = 16,
  localparam int CNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_sum,
  input  logic                 in_overflow,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_total,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic [CNT_WIDTH-1:0] out_carry_cnt,
  output logic                 out_sat
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_carry;
  logic                 r_sat;

  logic                 w_done;
  logic                 w_accept;
  logic [ACC_WIDTH:0]   w_v;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_done   = (r_state == DONE);
  assign in_ready = !w_done;
  assign w_accept = in_valid && in_ready;

  // One spare bit above the accumulator exposes overflow of the running add.
  assign w_v   = (ACC_WIDTH + 1)'({in_overflow, in_sum});
  assign w_sum = {1'b0, r_acc} + w_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= w_v[ACC_WIDTH-1:0];
            r_cnt   <= CNT_WIDTH'(1);
            r_carry <= CNT_WIDTH'(in_overflow);
            r_sat   <= 1'b0;
            r_state <= (in_last || MAX_COUNT == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum[ACC_WIDTH] ? '1 : w_sum[ACC_WIDTH-1:0];
            r_sat   <= r_sat | w_sum[ACC_WIDTH];
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
            r_carry <= r_carry + CNT_WIDTH'(in_overflow);
            r_state <= (in_last || r_cnt == CNT_WIDTH'(MAX_COUNT - 1)) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= '0;
            r_sat   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result fields are only visible while a block is being presented.
  assign out_valid     = w_done;
  assign out_total     = w_done ? r_acc   : '0;
  assign out_count     = w_done ? r_cnt   : '0;
  assign out_carry_cnt = w_done ? r_carry : '0;
  assign out_sat       = w_done ? r_sat   : 1'b0;

endmodule
